// File: rtl/frac_baud_generator.sv
// frac_baud_generator: fractional baud/oversample tick generator; fractional accumulator built only with BAUD_FRAC_EN
module frac_baud_generator #(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int INT_BITS   = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DEF_INT    = CLOCK_HZ / (OVERSAMPLE * BAUD),
  parameter int DEF_FRAC   = ((CLOCK_HZ % (OVERSAMPLE * BAUD)) << FRAC_BITS) / (OVERSAMPLE * BAUD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sync,
  input  logic                          cfg_we,
  input  logic [INT_BITS-1:0]           cfg_div_int,
  input  logic [FRAC_BITS-1:0]          cfg_div_frac,
  output logic                          cfg_pending,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int LW = INT_BITS + 1;
  localparam logic [LW-1:0] DEF_LEN = DEF_INT < 2 ? LW'(2) : LW'(DEF_INT);
  logic [INT_BITS-1:0] cnt, act_int, sh_int, eff_int;
  logic [LW-1:0] len, base;
  logic run, term, apply, carry, pending, wrap;
  assign cfg_pending = pending;
  assign run = en & ~sync;
  assign term = {1'b0, cnt} == len - LW'(1);
  assign apply = ~en | sync | term;
  // the divisor taking effect at this edge: a pending shadow wins over the active copy
  assign eff_int = pending ? sh_int : act_int;
  assign base = eff_int < INT_BITS'(2) ? LW'(2) : {1'b0, eff_int};
  assign wrap = os_phase == PW'(OVERSAMPLE - 1);
`ifdef BAUD_FRAC_EN
  logic [FRAC_BITS-1:0] acc, act_frac, sh_frac, eff_frac, acc_sum;
  assign eff_frac = pending ? sh_frac : act_frac;
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, eff_frac};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      act_frac <= FRAC_BITS'(DEF_FRAC);
      sh_frac <= FRAC_BITS'(DEF_FRAC);
    end else begin
      if (cfg_we) sh_frac <= cfg_div_frac;
      if (apply) act_frac <= sh_frac;
      acc <= !run ? '0 : term ? acc_sum : acc;
    end
  end
`else
  logic unused_frac;
  assign carry = 1'b0;
  assign unused_frac = ^{cfg_div_frac, FRAC_BITS'(DEF_FRAC)};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len <= DEF_LEN;
      act_int <= INT_BITS'(DEF_INT);
      sh_int <= INT_BITS'(DEF_INT);
      pending <= 1'b0;
      os_tick <= 1'b0;
      bit_tick <= 1'b0;
      os_phase <= '0;
    end else begin
      if (cfg_we) sh_int <= cfg_div_int;
      if (apply) act_int <= sh_int;
      pending <= cfg_we | (pending & ~apply);
      os_tick <= run & term;
      bit_tick <= run & term & wrap;
      cnt <= (run && !term) ? cnt + INT_BITS'(1) : '0;
      len <= !run ? base : term ? base + LW'(carry) : len;
      os_phase <= !run ? '0 : !term ? os_phase : wrap ? '0 : os_phase + PW'(1);
    end
  end
endmodule

// File: doc/frac_baud_generator.md
# frac_baud_generator

Programmable fractional baud-rate tick generator; next-generation replacement for the fixed integer divider feeding the UART TX/RX paths. Produces a one-cycle oversample enable, a bit-rate enable and an oversample phase index. The divisor is runtime-reloadable and takes effect glitch-free at a tick boundary. A `sync` input lets the RX front end realign phase on a start-bit edge.

## Interface
- `CLOCK_HZ`, 100_000_000, input clock frequency.
- `BAUD`, 115_200, default baud rate.
- `OVERSAMPLE`, 16, oversample ticks per bit; must be ≥2.
- `INT_BITS`, 16, width of the integer divisor.
- `FRAC_BITS`, 8, width of the fractional divisor and accumulator.
- `DEF_INT`, CLOCK_HZ / (OVERSAMPLE*BAUD), reset integer divisor (54 at defaults).
- `DEF_FRAC`, ((CLOCK_HZ % (OVERSAMPLE*BAUD)) << FRAC_BITS) / (OVERSAMPLE*BAUD), reset fractional divisor (64 at defaults).
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. When low, the generator is held idle.
- `sync` in 1: phase restart.
- `cfg_we` in 1: load strobe for `cfg_div_int`/`cfg_div_frac`.
- `cfg_div_int` in INT_BITS: integer clocks per oversample tick.
- `cfg_div_frac` in FRAC_BITS: fractional part, in units of 2^-FRAC_BITS.
- `cfg_pending` out 1: a loaded divisor is waiting to be applied.
- `os_tick` out 1: one-cycle oversample enable.
- `bit_tick` out 1: one-cycle bit enable, coincident with every OVERSAMPLE-th `os_tick`.
- `os_phase` out $clog2(OVERSAMPLE): `os_tick` count modulo OVERSAMPLE.

## Operation
- State: `cnt` (INT_BITS), `acc` (FRAC_BITS), `len` (current period length, INT_BITS+1), active divisor, shadow divisor, `os_phase`.
- Period: `cnt` runs 0..len-1. At terminal count (`cnt`==len-1):
  - `cnt`←0 and `os_tick`←1 on the next edge.
  - {c, `acc`} ← `acc` + active_frac.
  - `len` ← active_int + c.
  - Average period = int + frac/2^FRAC_BITS.
  - The first period after reset, idle or `sync` has `len` = active_int.
- Clamp: an active_int below 2 is treated as 2.
- Reload: on `cfg_we`, the shadow register is written and `cfg_pending`←1.
  - The shadow is copied to the active divisor at the next terminal count, `sync`, or any cycle with `en`=0. `cfg_pending` clears on that same edge.
  - A second `cfg_we` before the apply overwrites the shadow; the last write wins.
  - If `cfg_we` and apply occur in the same cycle, the apply uses the old shadow and the new value stays pending.
- `os_phase` increments on each `os_tick` edge and wraps OVERSAMPLE-1→0. `bit_tick`=1 on the `os_tick` cycle where `os_phase` becomes 0.
- `sync`=1 (with `en`=1): on the next edge `cnt`, `acc` and `os_phase` clear, `len`←active_int, and no tick is issued that edge. `sync` overrides a coincident terminal count.
- `en`=0: `cnt`, `acc` and `os_phase` are held at 0 and ticks are 0. After `en` rises, behaviour is identical to leaving reset.
- Priority: `rst` > `en`=0 > `sync` > terminal count.

## Timing
- Reset values:
  - `os_tick`, `bit_tick`, `os_phase`, `cfg_pending`, `cnt` and `acc` are 0.
  - Active and shadow divisor = DEF_INT/DEF_FRAC.
- All outputs are registered; there is no combinational input→output path.
- With `en`=1 from the first edge after reset and divisor N.0, `os_tick` is high for exactly one cycle every N cycles. The first `os_tick` is high after N edges.
- `cfg_we`→`cfg_pending` high: 1 cycle.
- A reload changes the period starting with the period immediately after the next `os_tick`. No truncated or stretched period is ever produced.
- `rst` asserted mid-period aborts it. The next `os_tick` occurs DEF_INT cycles after reset release.

## Configuration
- `BAUD_FRAC_EN` defined: fractional accumulator present, as described above.
- `BAUD_FRAC_EN` undefined:
  - `acc` is not built, `cfg_div_frac` is ignored, and every period = active_int exactly.
  - The port list is unchanged.

## Test plan
- Reset with defaults, `en`=1, `BAUD_FRAC_EN` undefined → `os_tick` every 54 cycles; `bit_tick` every 864 cycles; `os_phase` steps 1..15,0.
- `BAUD_FRAC_EN` defined, load int=4, frac=128 while `en`=0 → periods 4,4,5,4,5,…; the first 256 periods total 1151 cycles.
- Mid-period `cfg_we` int=10 (from 54) → `cfg_pending`=1 for the rest of the current period; that period stays 54; subsequent periods are 10; `cfg_pending`=0 after the apply.
- `sync` pulse in the same cycle as a terminal count, int=8 → no `os_tick`; the next `os_tick` follows 8 cycles later with `os_phase`=1.
- `cfg_div_int`=0 or 1 → periods of 2 cycles.
- `rst` asserted at `cnt`=30 with int=54 → all outputs 0 next cycle; the first `os_tick` comes 54 cycles after release.
